// File: rtl/fetch_unit_if.sv
// fetch_unit bus bundle: instruction memory port, decode handshake,
// redirect input and status outputs.
interface fetch_unit_if #(
  parameter int AW = 8,
  parameter int IW = 8
);
  logic [AW-1:0] imem_addr;
  logic          imem_req;
  logic          imem_ack;
  logic [IW-1:0] imem_data;
  logic [3:0]    opcd;
  logic [IW-5:0] oprnd;
  logic          ivalid;
  logic          iready;
  logic          jmp_en;
  logic [AW-1:0] jmp_addr;
  logic [AW-1:0] pc;
  logic          halted;

  modport master (
    output imem_addr, imem_req, opcd, oprnd, ivalid, pc, halted,
    input  imem_ack, imem_data, iready, jmp_en, jmp_addr
  );

  modport slave (
    input  imem_addr, imem_req, opcd, oprnd, ivalid, pc, halted,
    output imem_ack, imem_data, iready, jmp_en, jmp_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: holds the PC, reads instruction words over a
// req/ack port, presents opcode/operand to decode under valid/ready, handles
// jump redirects from execute and stops permanently on the HALT opcode.
module fetch_unit #(
  parameter int         AW      = 8,
  parameter int         IW      = 8,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [1:0]    r_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_imem_addr;
  logic          r_imem_req;
  logic          r_ivalid;
  logic [3:0]    r_opcd;
  logic [IW-5:0] r_oprnd;
  logic          r_halted;

  logic [3:0]    w_opcode;
  logic [IW-5:0] w_operand;

  assign w_opcode  = bus.imem_data[IW-1:IW-4];
  assign w_operand = bus.imem_data[IW-5:0];

  // Sequencer state and all registered outputs; redirect outranks everything
  // except reset, and an ack coincident with a redirect is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= {AW{1'b0}};
      r_imem_addr <= {AW{1'b0}};
      r_imem_req  <= 1'b0;
      r_ivalid    <= 1'b0;
      r_opcd      <= 4'b0000;
      r_oprnd     <= {(IW-4){1'b0}};
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
          if (bus.jmp_en) begin
            r_pc        <= bus.jmp_addr;
            r_imem_addr <= bus.jmp_addr;
          end else begin
            r_imem_addr <= r_pc;
          end
        end
        S_FETCH: begin
          if (bus.jmp_en) begin
            r_pc        <= bus.jmp_addr;
            r_imem_addr <= bus.jmp_addr;
            r_imem_req  <= 1'b1;
          end else if (bus.imem_ack) begin
            r_imem_req <= 1'b0;
            if (w_opcode == HALT_OP) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_opcd   <= w_opcode;
              r_oprnd  <= w_operand;
              r_ivalid <= 1'b1;
              r_pc     <= r_pc + PC_ONE;
              r_state  <= S_ISSUE;
            end
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (bus.jmp_en) begin
            // Accepted or withdrawn, the slot is freed either way.
            r_ivalid    <= 1'b0;
            r_pc        <= bus.jmp_addr;
            r_imem_addr <= bus.jmp_addr;
            r_imem_req  <= 1'b1;
            r_state     <= S_FETCH;
          end else if (bus.iready) begin
            r_ivalid    <= 1'b0;
            r_imem_addr <= r_pc;
            r_imem_req  <= 1'b1;
            r_state     <= S_FETCH;
          end else begin
            r_ivalid <= 1'b1;
          end
        end
        S_HALT: begin
          r_imem_req <= 1'b0;
          r_ivalid   <= 1'b0;
          r_halted   <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
          r_ivalid   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr = r_imem_addr;
  assign bus.imem_req  = r_imem_req;
  assign bus.opcd      = r_opcd;
  assign bus.oprnd     = r_oprnd;
  assign bus.ivalid    = r_ivalid;
  assign bus.pc        = r_pc;
  assign bus.halted    = r_halted;

endmodule
